// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: opcode and FSM state enumerations,
// opcode field width, and a helper that classifies the add-class opcodes.
// Imported by seq_alu and seq_alu_mul.
package seq_alu_pkg;

  localparam int unsigned OP_W = 4;

  // Opcodes 1010-1111 are not listed; they complete as single-cycle ops with y = 0.
  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 4'b0000,
    OP_SHL  = 4'b0001,
    OP_INC  = 4'b0010,
    OP_INC2 = 4'b0011,
    OP_NOT  = 4'b0100,
    OP_AND  = 4'b0101,
    OP_OR   = 4'b0110,
    OP_XOR  = 4'b0111,
    OP_SUB  = 4'b1000,
    OP_MUL  = 4'b1001
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Add-class ops (0000-0011) are the only ones that report a carry-out.
  function automatic logic is_add_class(input logic [OP_W-1:0] op);
    return (op[3:2] == 2'b00);
  endfunction

endpackage

// File: rtl/seq_alu_mul.sv
// Shift-add unsigned multiplier: one bit of B consumed per cycle, WIDTH cycles.
// Ports: i_clk/i_rst (sync, active-high), i_start loads i_a/i_b,
//        o_finish pulses one cycle when o_prod holds the full 2*WIDTH-bit product.
module seq_alu_mul
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_finish,
  output logic [2*WIDTH-1:0] o_prod
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] r_prod;   // upper half: partial sum, lower half: remaining B bits
  logic [WIDTH-1:0]   r_mcand;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_run;

  logic               w_last;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod_next;

  assign w_last = (r_cnt == CNT_W'(WIDTH));

  // Add the multiplicand into the upper half when the current B bit is set,
  // then shift the whole register right; the carry of the add lands in the MSB.
  always_comb begin
    w_sum = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
    if (r_prod[0]) begin
      w_prod_next = {w_sum, r_prod[WIDTH-1:1]};
    end else begin
      w_prod_next = {1'b0, r_prod[2*WIDTH-1:1]};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prod  <= '0;
      r_mcand <= '0;
      r_cnt   <= '0;
      r_run   <= 1'b0;
    end else if (i_start) begin
      r_prod  <= {{WIDTH{1'b0}}, i_b};
      r_mcand <= i_a;
      r_cnt   <= '0;
      r_run   <= 1'b1;
    end else if (r_run) begin
      if (w_last) begin
        // Finish has been presented for one cycle; stop so it does not repeat.
        r_run <= 1'b0;
      end else begin
        r_prod <= w_prod_next;
        r_cnt  <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_finish = r_run && w_last;
  assign o_prod   = r_prod;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ops via EXEC (done 2 cycles after start),
// multiply via seq_alu_mul (done WIDTH+2 cycles after start).
// Ports: clk, rst (sync active-high), start/op/a/b request sampled in IDLE only,
//        busy/done status, registered y (2*WIDTH) with zero and carry flags.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [OP_W-1:0]    op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] y,
  output logic               zero,
  output logic               carry
);

  state_e             r_state;
  state_e             w_next_state;

  logic [OP_W-1:0]    r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;

  logic [2*WIDTH-1:0] r_y;
  logic               r_zero;
  logic               r_carry;

  logic               w_accept;
  logic               w_mul_start;
  logic               w_mul_finish;
  logic [2*WIDTH-1:0] w_mul_prod;
  logic [2*WIDTH-1:0] w_res;
  logic               w_res_carry;

  // start is only looked at in IDLE; anything arriving while busy is dropped.
  assign w_accept    = (r_state == S_IDLE) && start;
  assign w_mul_start = w_accept && (op == OP_MUL);

  // The multiplier loads a/b on the same edge the top captures them.
  seq_alu_mul #(
    .WIDTH(WIDTH)
  ) u_mul (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (w_mul_start),
    .i_a     (a),
    .i_b     (b),
    .o_finish(w_mul_finish),
    .o_prod  (w_mul_prod)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op <= '0;
      r_a  <= '0;
      r_b  <= '0;
    end else if (w_accept) begin
      r_op <= op;
      r_a  <= a;
      r_b  <= b;
    end
  end

  // Single-cycle datapath from the captured operands; bits above each op's
  // natural width stay zero from the default.
  always_comb begin
    w_res = '0;
    unique case (r_op)
      OP_ADD:  w_res[WIDTH:0]   = {1'b0, r_a} + {1'b0, r_b};
      OP_SHL:  w_res[WIDTH:0]   = {r_a, 1'b0};
      OP_INC:  w_res[WIDTH:0]   = {1'b0, r_a} + (WIDTH+1)'(1);
      OP_INC2: w_res[WIDTH:0]   = {1'b0, r_a} + (WIDTH+1)'(2);
      OP_NOT:  w_res[WIDTH-1:0] = ~r_a;
      OP_AND:  w_res[WIDTH-1:0] = r_a & r_b;
      OP_OR:   w_res[WIDTH-1:0] = r_a | r_b;
      OP_XOR:  w_res[WIDTH-1:0] = r_a ^ r_b;
      // Extended subtract: bit WIDTH of the (WIDTH+1)-bit difference is the borrow.
      OP_SUB:  w_res[WIDTH:0]   = {1'b0, r_a} - {1'b0, r_b};
      default: w_res            = '0;
    endcase
    w_res_carry = is_add_class(r_op) && w_res[WIDTH];
  end

  // Result registers change only on the transition into DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_y     <= '0;
      r_zero  <= 1'b1;
      r_carry <= 1'b0;
    end else if (r_state == S_EXEC) begin
      r_y     <= w_res;
      r_zero  <= (w_res == '0);
      r_carry <= w_res_carry;
    end else if ((r_state == S_MUL) && w_mul_finish) begin
      r_y     <= w_mul_prod;
      r_zero  <= (w_mul_prod == '0);
      r_carry <= 1'b0;
    end
  end

  always_comb begin
    w_next_state = r_state;
    busy         = 1'b1;
    done         = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_next_state = (op == OP_MUL) ? S_MUL : S_EXEC;
        end
      end
      S_EXEC: begin
        w_next_state = S_DONE;
      end
      S_MUL: begin
        if (w_mul_finish) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        done         = 1'b1;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  assign y     = r_y;
  assign zero  = r_zero;
  assign carry = r_carry;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed scenarios plus randomized ops on a WIDTH=8 and a
// WIDTH=4 instance, checked against a plain-arithmetic reference model.
module tb_seq_alu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start8, busy8, done8, zero8, carry8;
  logic [3:0]  op8;
  logic [7:0]  a8, b8;
  logic [15:0] y8;

  logic        start4, busy4, done4, zero4, carry4;
  logic [3:0]  op4;
  logic [3:0]  a4, b4;
  logic [7:0]  y4;

  int n_tests = 0;
  int n_fail  = 0;

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .y(y8), .zero(zero8), .carry(carry8)
  );

  seq_alu #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .op(op4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .y(y4), .zero(zero4), .carry(carry4)
  );

  // Reference: result of each opcode as plain unsigned arithmetic on w-bit operands.
  function automatic longint unsigned model_y(input int w, input int o,
                                              input longint unsigned aa,
                                              input longint unsigned bb);
    longint unsigned m = (64'd1 << w) - 1;
    case (o)
      0: return aa + bb;
      1: return aa * 2;
      2: return aa + 1;
      3: return aa + 2;
      4: return (~aa) & m;
      5: return aa & bb;
      6: return aa | bb;
      7: return aa ^ bb;
      8: return ((aa - bb) & m) | ((aa < bb) ? (64'd1 << w) : 64'd0);
      9: return aa * bb;
      default: return 0;
    endcase
  endfunction

  function automatic bit model_carry(input int w, input int o, input longint unsigned yy);
    return (o <= 3) && yy[w];
  endfunction

  // Issue one request, scramble the inputs right after capture, wait for done.
  task automatic do8(input logic [3:0] o, input logic [7:0] aa, input logic [7:0] bb,
                     output int lat, output bit got);
    @(negedge clk);
    start8 = 1'b1; op8 = o; a8 = aa; b8 = bb;
    @(posedge clk);
    #1;
    start8 = 1'b0; op8 = 4'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
    lat = 0; got = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done8) begin lat = i; got = 1'b1; break; end
    end
  endtask

  task automatic do4(input logic [3:0] o, input logic [3:0] aa, input logic [3:0] bb,
                     output int lat, output bit got);
    @(negedge clk);
    start4 = 1'b1; op4 = o; a4 = aa; b4 = bb;
    @(posedge clk);
    #1;
    start4 = 1'b0; op4 = 4'($urandom); a4 = 4'($urandom); b4 = 4'($urandom);
    lat = 0; got = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done4) begin lat = i; got = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      n_fail++; $display("FAIL reset_status busy=%b done=%b expected 0/0", busy8, done8);
    end
    n_tests++;
    if (y8 !== 16'h0000 || zero8 !== 1'b1 || carry8 !== 1'b0) begin
      n_fail++; $display("FAIL reset_result y=%h zero=%b carry=%b expected 0000/1/0", y8, zero8, carry8);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add_carry;
    int lat; bit got;
    do8(4'b0000, 8'hFF, 8'h01, lat, got);
    n_tests++;
    if (!got || lat !== 2) begin
      n_fail++; $display("FAIL add_latency got=%0d lat=%0d expected 2", got, lat);
    end
    n_tests++;
    if (y8 !== 16'h0100 || carry8 !== 1'b1 || zero8 !== 1'b0) begin
      n_fail++; $display("FAIL add_result y=%h c=%b z=%b expected 0100/1/0", y8, carry8, zero8);
    end
  endtask

  task automatic test_sub_borrow;
    int lat; bit got;
    do8(4'b1000, 8'h05, 8'h07, lat, got);
    n_tests++;
    if (!got || y8 !== 16'h01FE || carry8 !== 1'b0 || zero8 !== 1'b0) begin
      n_fail++; $display("FAIL sub_borrow got=%0d y=%h c=%b z=%b expected 01FE/0/0", got, y8, carry8, zero8);
    end
  endtask

  task automatic test_mul_ignore_start;
    int lat = 0; int busy_cnt = 0; bit extra = 1'b0;
    @(negedge clk);
    start8 = 1'b1; op8 = 4'b1001; a8 = 8'hFF; b8 = 8'hFF;
    @(posedge clk);
    #1;
    start8 = 1'b0; op8 = 4'b0000; a8 = 8'h01; b8 = 8'h01;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done8) begin lat = i; break; end
      if (busy8) busy_cnt++;
      start8 = (i == 4);  // second request while the multiply is running
    end
    start8 = 1'b0;
    n_tests++;
    if (lat !== 10 || busy_cnt !== 9) begin
      n_fail++; $display("FAIL mul_timing lat=%0d busy=%0d expected 10/9", lat, busy_cnt);
    end
    n_tests++;
    if (y8 !== 16'hFE01 || carry8 !== 1'b0 || zero8 !== 1'b0) begin
      n_fail++; $display("FAIL mul_result y=%h c=%b z=%b expected FE01/0/0", y8, carry8, zero8);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy8 || done8 || y8 !== 16'hFE01) extra = 1'b1;
    end
    n_tests++;
    if (extra) begin
      n_fail++; $display("FAIL mul_no_queue busy=%b y=%h expected idle holding FE01", busy8, y8);
    end
  endtask

  task automatic test_logic;
    int lat; bit got;
    do8(4'b0101, 8'hF0, 8'h0F, lat, got);
    n_tests++;
    if (!got || y8 !== 16'h0000 || zero8 !== 1'b1) begin
      n_fail++; $display("FAIL and_zero y=%h z=%b expected 0000/1", y8, zero8);
    end
    do8(4'b0100, 8'h00, 8'hAA, lat, got);
    n_tests++;
    if (!got || y8 !== 16'h00FF || zero8 !== 1'b0 || carry8 !== 1'b0) begin
      n_fail++; $display("FAIL not_result y=%h z=%b c=%b expected 00FF/0/0", y8, zero8, carry8);
    end
  endtask

  task automatic test_reset_abort;
    int lat; bit got; bit saw_done = 1'b0;
    @(negedge clk);
    start8 = 1'b1; op8 = 4'b1001; a8 = 8'h12; b8 = 8'h34;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done8) saw_done = 1'b1;
    end
    n_tests++;
    if (saw_done || busy8 !== 1'b0 || y8 !== 16'h0000 || zero8 !== 1'b1) begin
      n_fail++; $display("FAIL abort done_seen=%b busy=%b y=%h z=%b expected 0/0/0000/1", saw_done, busy8, y8, zero8);
    end
    do8(4'b0010, 8'h7F, 8'h00, lat, got);
    n_tests++;
    if (!got || y8 !== 16'h0080 || carry8 !== 1'b0) begin
      n_fail++; $display("FAIL after_abort_inc y=%h c=%b expected 0080/0", y8, carry8);
    end
  endtask

  task automatic test_rst_beats_start;
    bit bad = 1'b0;
    @(negedge clk);
    rst = 1'b1; start8 = 1'b1; op8 = 4'b0000; a8 = 8'h01; b8 = 8'h01;
    @(negedge clk);
    rst = 1'b0; start8 = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (busy8 || done8) bad = 1'b1;
    end
    n_tests++;
    if (bad || y8 !== 16'h0000) begin
      n_fail++; $display("FAIL rst_vs_start busy/done seen=%b y=%h expected none/0000", bad, y8);
    end
  endtask

  task automatic test_back_to_back;
    int bad = 0;
    @(negedge clk);
    start8 = 1'b1; op8 = 4'b0010; a8 = 8'h01; b8 = 8'h00;
    // Sampling edge, EXEC, DONE, IDLE(resample) -> done every third cycle.
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (done8 !== ((i % 3) == 2)) bad++;
    end
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    n_tests++;
    if (bad != 0 || y8 !== 16'h0002) begin
      n_fail++; $display("FAIL back_to_back wrong_cycles=%0d y=%h expected 0/0002", bad, y8);
    end
  endtask

  task automatic test_random8;
    int lat; bit got; int o; logic [7:0] aa, bb;
    longint unsigned ey; int bad = 0;
    for (int k = 0; k < 60; k++) begin
      o = $urandom_range(0, 15); aa = 8'($urandom); bb = 8'($urandom);
      do8(4'(o), aa, bb, lat, got);
      ey = model_y(8, o, aa, bb);
      n_tests++;
      if (!got || lat != ((o == 9) ? 10 : 2) || y8 !== ey[15:0] || zero8 !== (ey == 0)
          || carry8 !== model_carry(8, o, ey)) begin
        n_fail++; bad++;
        if (bad <= 5)
          $display("FAIL rand8 op=%0d a=%h b=%h lat=%0d y=%h z=%b c=%b expected lat=%0d y=%h",
                   o, aa, bb, lat, y8, zero8, carry8, (o == 9) ? 10 : 2, ey[15:0]);
      end
    end
  endtask

  task automatic test_width4;
    int lat; bit got; logic [3:0] aa, bb;
    longint unsigned ey;
    for (int o = 0; o < 8; o++) begin
      for (int k = 0; k < 4; k++) begin
        aa = 4'($urandom); bb = 4'($urandom);
        do4(4'(o), aa, bb, lat, got);
        ey = model_y(4, o, aa, bb);
        n_tests++;
        if (!got || lat != 2 || y4 !== ey[7:0] || carry4 !== model_carry(4, o, ey)
            || zero4 !== (ey == 0)) begin
          n_fail++;
          $display("FAIL w4 op=%0d a=%h b=%h y=%h c=%b expected y=%h c=%b",
                   o, aa, bb, y4, carry4, ey[7:0], model_carry(4, o, ey));
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    start4 = 1'b0; op4 = '0; a4 = '0; b4 = '0;
    test_reset();
    test_add_carry();
    test_sub_borrow();
    test_mul_ignore_start();
    test_logic();
    test_reset_abort();
    test_rst_beats_start();
    test_back_to_back();
    test_random8();
    test_width4();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: start  input  1  request; sampled only in IDLE.
REQ-005 Port: op  input  4  operation select; sampled with start.
REQ-006 Port: a, b  input  WIDTH each  operands; sampled with start.
REQ-007 Port: busy  output  1  high in any state other than IDLE.
REQ-008 Port: done  output  1  one-cycle pulse when y and flags become valid.
REQ-009 Port: y  output  2*WIDTH  registered result, zero-extended above the op's natural width.
REQ-010 Port: zero  output  1  high when y == 0.
REQ-011 Port: carry  output  1  high when y[WIDTH] is set by an add-class op; low for all other ops.

Function
REQ-012 Ops: 0000 A+B; 0001 A<<1; 0010 A+1; 0011 A+2; 0100 ~A; 0101 A&B; 0110 A|B; 0111 A^B; 1000 A-B; 1001 A*B (unsigned).
REQ-013 Add-class ops (0000-0011) shall produce a WIDTH+1-bit result. Bit WIDTH is the carry-out.
REQ-014 1000 shall produce a WIDTH-bit two's-complement difference. y[WIDTH] = borrow (A<B), and carry = 0.
REQ-015 Logic ops (0100-0111) shall produce WIDTH bits. All upper bits of y shall be 0.
REQ-016 1001 shall produce the full 2*WIDTH-bit unsigned product by iterative shift-add, one bit of B per cycle.
REQ-017 Opcodes 1010-1111 shall complete as single-cycle ops with y = 0 and zero = 1.
REQ-018 The FSM shall have the states IDLE, EXEC, MUL and DONE.
REQ-019 IDLE with start=1: capture op, a and b. Go to MUL if op = 1001, otherwise go to EXEC.
REQ-020 EXEC: compute the result and go to DONE (one cycle).
REQ-021 MUL: run exactly WIDTH cycles, counted by a $clog2(WIDTH+1)-bit counter, then go to DONE.
REQ-022 DONE: y, zero and carry shall be updated on entry, done = 1 for exactly this cycle, and the next state is IDLE.
REQ-023 Latency from the edge that samples start to the done cycle: 2 cycles for single-cycle ops; WIDTH+2 cycles for MUL.
REQ-024 start asserted while busy = 1 shall be ignored, with no queuing.
REQ-025 Changes to a, b or op after capture shall not affect the operation in flight.
REQ-026 y and the flags shall hold their last value until the next DONE.
REQ-027 start held high continuously shall start a new operation on the first IDLE cycle after each DONE.

Reset
REQ-028 rst=1 at a rising edge shall force state to IDLE, y = 0, zero = 1, carry = 0, busy = 0, done = 0, and clear the counter and operand registers.
REQ-029 Reset during EXEC, MUL or DONE shall abort the operation, and no done pulse shall be issued for it.
REQ-030 A start and rst asserted in the same cycle: rst shall win, and the start is lost.

Structure
REQ-031 A shared package seq_alu_pkg shall hold the op enumeration (4-bit), the state enumeration, and the opcode constants.
REQ-032 One sub-module, seq_alu_mul, shall contain the shift-add multiplier datapath and its counter, with a start/finish interface to the top FSM.
REQ-033 Single-cycle ops shall be implemented combinationally from the captured operands and registered in DONE. There shall be no latches.

Verification
REQ-034 WIDTH=8: op=0000, a=0xFF, b=0x01 -> done after 2 cycles, y=0x0100, carry=1, zero=0.
REQ-035 WIDTH=8: op=1000, a=0x05, b=0x07 -> y[7:0]=0xFE, y[8]=1 (borrow), carry=0.
REQ-036 WIDTH=8: op=1001, a=0xFF, b=0xFF -> busy for 9 cycles, done at cycle 10, y=0xFE01. A second start pulse issued mid-multiply is ignored.
REQ-037 WIDTH=8: op=0101, a=0xF0, b=0x0F -> y=0x0000, zero=1; then op=0100, a=0x00 -> y=0x00FF.
REQ-038 WIDTH=8: op=1001 started, rst pulsed at MUL cycle 4 -> no done pulse, busy=0, y=0, zero=1; the next op=0010, a=0x7F gives y=0x0080.
REQ-039 WIDTH=4 regression: all 8 legacy ops (0000-0111) with random a and b match the 5-bit reference arithmetic in y[4:0].
